// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/mem/writeback over a single
// shared memory port and drives datapath enables, ALU control and the memory handshake.
module core_sequencer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        isZero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_fetch,
  output logic        instr_we,
  output logic        pc_we,
  output logic        regWrite,
  output logic        isALUreg,
  output logic        isJAL,
  output logic        isJALR,
  output logic        isBranch,
  output logic        isLUI,
  output logic        isAUIPC,
  output logic        isLoad,
  output logic        isStore,
  output logic [3:0]  aluControl,
  output logic        branch_taken,
  output logic        fault,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StStart   = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExecute = 3'd3,
    StMem     = 3'd4,
    StWb      = 3'd5,
    StTrap    = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        instret_q, instret_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        cnt_ext;
  logic               timeout_hit;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
  logic       is_opimm, is_op, legal, dec_valid;
  logic [3:0] alu_ctl;
  logic       br_cond;

  logic unused_instr;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign is_lui    = (opcode == 7'b0110111);
  assign is_auipc  = (opcode == 7'b0010111);
  assign is_jal    = (opcode == 7'b1101111);
  assign is_jalr   = (opcode == 7'b1100111);
  assign is_branch = (opcode == 7'b1100011);
  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_opimm  = (opcode == 7'b0010011);
  assign is_op     = (opcode == 7'b0110011);
  // Every legal opcode ends in 2'b11, so this also rejects compressed encodings.
  assign legal = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store |
                 is_opimm | is_op;

  assign dec_valid = (state_q == StDecode) || (state_q == StExecute) ||
                     (state_q == StMem) || (state_q == StWb);

  assign isALUreg = dec_valid & is_op;
  assign isJAL    = dec_valid & is_jal;
  assign isJALR   = dec_valid & is_jalr;
  assign isBranch = dec_valid & is_branch;
  assign isLUI    = dec_valid & is_lui;
  assign isAUIPC  = dec_valid & is_auipc;
  assign isLoad   = dec_valid & is_load;
  assign isStore  = dec_valid & is_store;

  always_comb begin
    alu_ctl = 4'b0000;
    if (is_op) begin
      alu_ctl = {((funct3 == 3'b000) || (funct3 == 3'b101)) & instr[30], funct3};
    end else if (is_opimm) begin
      alu_ctl = {(funct3 == 3'b101) & instr[30], funct3};
    end else if (is_branch) begin
      case (funct3[2:1])
        2'b00:   alu_ctl = 4'b1000;
        2'b10:   alu_ctl = 4'b0010;
        2'b11:   alu_ctl = 4'b0011;
        default: alu_ctl = 4'b0000;
      endcase
    end
  end

  assign aluControl = dec_valid ? alu_ctl : 4'b0000;

  // The ALU computes equality for BEQ/BNE and a set-less-than for the ordered compares,
  // so zero means "not less than" in the latter case.
  always_comb begin
    case (funct3)
      3'b000:         br_cond = isZero;
      3'b001:         br_cond = ~isZero;
      3'b100, 3'b110: br_cond = ~isZero;
      3'b101, 3'b111: br_cond = isZero;
      default:        br_cond = 1'b0;
    endcase
  end

  assign branch_taken = (state_q == StExecute) & is_branch & br_cond;

  assign cnt_ext     = 32'(cnt_q) + 32'd1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_ext == TIMEOUT);

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    instr_we     = 1'b0;
    pc_we        = 1'b0;
    regWrite     = 1'b0;
    case (state_q)
      StStart: state_d = StFetch;
      StFetch: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        if (mem_ready) begin
          instr_we = 1'b1;
          state_d  = StDecode;
        end else if (timeout_hit) begin
          state_d = StTrap;
        end
      end
      StDecode: state_d = legal ? StExecute : StTrap;
      StExecute: begin
        if (is_load || is_store) begin
          state_d = StMem;
        end else begin
          pc_we    = 1'b1;
          regWrite = ~is_branch;
          state_d  = StFetch;
        end
      end
      StMem: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (timeout_hit) begin
          state_d = StTrap;
        end
      end
      StWb: begin
        regWrite = 1'b1;
        pc_we    = 1'b1;
        state_d  = StFetch;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase
  end

  always_comb begin
    if (((state_d != state_q) && ((state_d == StFetch) || (state_d == StMem))) || mem_ready) begin
      cnt_d = '0;
    end else if (mem_req) begin
      cnt_d = cnt_ext[CNT_W-1:0];
    end else begin
      cnt_d = cnt_q;
    end
    fault_d   = fault_q | (state_d == StTrap);
    instret_d = instret_q + 32'(pc_we);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StStart;
      instret_q <= '0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: walks ADDI/LW/SW/BNE/SUB/SRAI/illegal sequences,
// a fetch timeout and an asynchronous reset in the middle of a memory access.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        isZero;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_is_fetch, instr_we, pc_we, regWrite;
  logic        isALUreg, isJAL, isJALR, isBranch, isLUI, isAUIPC, isLoad, isStore;
  logic [3:0]  aluControl;
  logic        branch_taken, fault;
  logic [31:0] instret;
  logic [2:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  core_sequencer #(
    .TIMEOUT(4),
    .CNT_W  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .isZero      (isZero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_is_fetch(mem_is_fetch),
    .instr_we    (instr_we),
    .pc_we       (pc_we),
    .regWrite    (regWrite),
    .isALUreg    (isALUreg),
    .isJAL       (isJAL),
    .isJALR      (isJALR),
    .isBranch    (isBranch),
    .isLUI       (isLUI),
    .isAUIPC     (isAUIPC),
    .isLoad      (isLoad),
    .isStore     (isStore),
    .aluControl  (aluControl),
    .branch_taken(branch_taken),
    .fault       (fault),
    .instret     (instret),
    .state       (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset     = 1'b1;
    instr     = 32'h0000_0000;
    isZero    = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_instret", instret, 0);
    check("rst_fault", 32'(fault), 0);
    tick();
    tick();

    // ADDI x1,x0,5 with memory always ready
    instr     = 32'h0050_0093;
    mem_ready = 1'b1;
    reset     = 1'b0;
    #1;
    check("start_state", 32'(state), 0);
    check("start_pc_we", 32'(pc_we), 0);
    tick();
    check("addi_fetch", 32'(state), 1);
    check("addi_fetch_req", 32'(mem_req), 1);
    check("addi_fetch_isf", 32'(mem_is_fetch), 1);
    check("addi_instr_we", 32'(instr_we), 1);
    tick();
    check("addi_decode", 32'(state), 2);
    check("addi_dec_en", 32'({pc_we, regWrite, mem_req, instr_we}), 0);
    tick();
    check("addi_exec", 32'(state), 3);
    check("addi_regwrite", 32'(regWrite), 1);
    check("addi_pc_we", 32'(pc_we), 1);
    check("addi_aluctl", 32'(aluControl), 0);
    check("addi_isalureg", 32'(isALUreg), 0);
    tick();
    check("addi_back_fetch", 32'(state), 1);
    check("addi_instret", instret, 1);

    // LW x2,0(x1) with two wait cycles in MEM
    instr = 32'h0000_A103;
    tick();
    check("lw_decode", 32'(state), 2);
    check("lw_isload", 32'(isLoad), 1);
    mem_ready = 1'b0;
    tick();
    check("lw_exec", 32'(state), 3);
    check("lw_exec_en", 32'({pc_we, regWrite}), 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("lw_mem_wait_state", 32'(state), 4);
      check("lw_mem_wait_req", 32'({mem_req, mem_we, mem_is_fetch}), 32'b100);
      check("lw_mem_wait_pc_we", 32'(pc_we), 0);
    end
    tick();
    mem_ready = 1'b1;
    #1;
    check("lw_mem_ready_state", 32'(state), 4);
    check("lw_mem_ready_req", 32'({mem_req, mem_we}), 32'b10);
    check("lw_mem_ready_en", 32'({pc_we, regWrite}), 0);
    tick();
    check("lw_wb", 32'(state), 5);
    check("lw_wb_en", 32'({regWrite, pc_we}), 32'b11);
    check("lw_wb_instret", instret, 1);
    tick();
    check("lw_fetch", 32'(state), 1);
    check("lw_instret", instret, 2);

    // SW x2,0(x1)
    instr = 32'h0020_A023;
    tick();
    check("sw_isstore", 32'(isStore), 1);
    tick();
    check("sw_exec_regwrite", 32'(regWrite), 0);
    tick();
    check("sw_mem", 32'(state), 4);
    check("sw_mem_we", 32'({mem_req, mem_we, mem_is_fetch}), 32'b110);
    check("sw_pc_we", 32'(pc_we), 1);
    check("sw_regwrite", 32'(regWrite), 0);
    tick();
    check("sw_fetch", 32'(state), 1);
    check("sw_instret", instret, 3);

    // BNE x1,x2,8
    instr  = 32'h0020_9463;
    isZero = 1'b0;
    tick();
    check("bne_decode_taken", 32'(branch_taken), 0);
    tick();
    check("bne_exec", 32'(state), 3);
    check("bne_aluctl", 32'(aluControl), 32'h8);
    check("bne_taken", 32'(branch_taken), 1);
    check("bne_pc_we", 32'({pc_we, regWrite}), 32'b10);
    isZero = 1'b1;
    #1;
    check("bne_not_taken", 32'(branch_taken), 0);
    check("bne_pc_we_nt", 32'(pc_we), 1);
    tick();
    check("bne_instret", instret, 4);
    isZero = 1'b0;

    // SUB then SRAI
    instr = 32'h4020_8033;
    tick();
    check("sub_aluctl", 32'(aluControl), 32'h8);
    check("sub_isalureg", 32'(isALUreg), 1);
    tick();
    tick();
    instr = 32'h4010_D093;
    tick();
    check("srai_aluctl", 32'(aluControl), 32'hD);
    check("srai_isalureg", 32'(isALUreg), 0);
    tick();
    tick();
    check("srai_instret", instret, 6);

    // Illegal instruction traps and stays trapped
    instr = 32'hFFFF_FFFF;
    tick();
    check("ill_decode", 32'(state), 2);
    tick();
    check("ill_trap", 32'(state), 7);
    check("ill_fault", 32'(fault), 1);
    check("ill_trap_flags", 32'({isLoad, isStore, isBranch, aluControl}), 0);
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i % 2 == 0);
      tick();
      check("trap_hold", 32'(state), 7);
      check("trap_en", 32'({pc_we, regWrite, mem_req}), 0);
    end
    check("trap_instret", instret, 6);
    reset = 1'b1;
    #1;
    check("trap_reset_fault", 32'(fault), 0);
    check("trap_reset_state", 32'(state), 0);

    // Fetch timeout: four request cycles without mem_ready, then TRAP
    mem_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("to_fetch_wait", 32'(state), 1);
      tick();
    end
    check("to_trap", 32'(state), 7);
    check("to_fault", 32'(fault), 1);
    check("to_mem_req", 32'(mem_req), 0);

    // Asynchronous reset in the middle of a load's MEM phase
    reset = 1'b1;
    tick();
    instr     = 32'h0050_0093;
    mem_ready = 1'b1;
    reset     = 1'b0;
    repeat (4) tick();
    check("ar_instret_pre", instret, 1);
    instr = 32'h0000_A103;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    check("ar_mem", 32'(state), 4);
    check("ar_mem_req", 32'(mem_req), 1);
    reset = 1'b1;
    #1;
    check("ar_state", 32'(state), 0);
    check("ar_mem_req_drop", 32'(mem_req), 0);
    check("ar_instret", instret, 0);
    check("ar_en", 32'({pc_we, regWrite}), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
